// File: rtl/sel_seq_pkg.sv
// ---------------------------------------------------------------------------
// sel_seq_pkg : shared types, constants and code helpers for select_sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sel_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] LAST_CODE = 3'd7;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/select_sequencer_dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter : hold-time counter with registered terminal-count flag
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] limit,
  output logic               tc
);

  logic [DWELL_W-1:0] count_q, count_d;
  logic               tc_q, tc_d;

  // limit is the value that will be in force next cycle, so tc_q always
  // matches (count_q == active limit) without a compare on the output path.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc_q ? '0 : count_q + 1'b1;
    end
    tc_d = (count_d == limit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign tc = tc_q;

endmodule

`default_nettype wire

// File: rtl/select_sequencer.sv
// ---------------------------------------------------------------------------
// select_sequencer : steps a 3-bit select code through all eight values with
//                    programmable dwell; SEL_SEQ_GRAY_EN selects Gray order.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module select_sequencer
  import sel_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic               x,
  output logic               y,
  output logic               z,
  output logic               valid,
  output logic               step,
  output logic               done
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0]  dwell_lat_q, dwell_lat_d;
  logic                cont_q, cont_d;
  logic                valid_q, valid_d;
  logic                step_q, step_d;
  logic                done_q, done_d;
  logic                tc;
  logic                cnt_clear;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    dwell_lat_d = dwell_lat_q;
    cont_d      = cont_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          dwell_lat_d = dwell;
          cont_d      = mode_cont;
          code_d      = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          code_d  = '0;
        end else if (tc) begin
          if (code_q != LAST_CODE) begin
            code_d = code_q + 1'b1;
            step_d = 1'b1;
          end else if (cont_q) begin
            code_d = '0;
            step_d = 1'b1;
          end else begin
            code_d  = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = '0;
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase
    valid_d = (state_d == RUN);
`ifdef SEL_SEQ_GRAY_EN
    sel_d = bin2gray(code_d);
`else
    sel_d = code_d;
`endif
  end

  // Count only while staying in RUN; any entry to or exit from RUN restarts it.
  assign cnt_clear = (state_q != RUN) || (state_d != RUN);

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (1'b1),
    .limit  (dwell_lat_d),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      sel_q       <= '0;
      dwell_lat_q <= '0;
      cont_q      <= 1'b0;
      valid_q     <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      sel_q       <= sel_d;
      dwell_lat_q <= dwell_lat_d;
      cont_q      <= cont_d;
      valid_q     <= valid_d;
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

  assign x     = sel_q[2];
  assign y     = sel_q[1];
  assign z     = sel_q[0];
  assign valid = valid_q;
  assign step  = step_q;
  assign done  = done_q;

endmodule

`default_nettype wire
